ext_credit_tx_ipa: RTL and testbench
====================================

Name: ext_credit_tx_ipa

Overview:
- Credit-based transmitter that drives a remote ext-unit receive buffer over a link with no backpressure wire.
- Accepts an upstream valid/ready stream and forwards each word as a one-cycle registered pulse.
- Holds one credit per free slot in the remote buffer and consumes a credit per word sent. The remote side returns a credit pulse per pop.
- Includes a drain/flush FSM so the ext unit can quiesce the link before reconfiguration of the IPA array.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- CREDITS, 2, initial credit count; must equal the remote buffer depth; legal range 1 or more.
- CNT_WIDTH, $clog2(CREDITS+1), width of the credit counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  upstream word valid.
- data_i  input  DATA_WIDTH  upstream word.
- ready_o  output  1  upstream ready; transfer fires when valid_i and ready_o.
- valid_o  output  1  link valid pulse, registered.
- data_o  output  DATA_WIDTH  link data, registered.
- credit_i  input  1  one-cycle pulse; the remote buffer freed one entry.
- credits_o  output  CNT_WIDTH  current credit count.
- flush_req_i  input  1  level request to drain the link.
- flush_done_o  output  1  the link is empty and all credits are home.
- err_o  output  1  sticky credit-overflow error.

Behaviour:
- Reset values:
  - cnt = CREDITS.
  - valid_o = 0.
  - data_o = 0.
  - FSM = RUN.
  - flush_done_o = 0.
  - err_o = 0.
- fire = valid_i && ready_o.
- ready_o = (state == RUN) && (cnt != 0). It depends on registered state only; there is no combinational path from credit_i or valid_i.
- Output register:
  - On fire: valid_o <= 1 and data_o <= data_i at the next edge (latency 1 cycle).
  - Without fire: valid_o <= 0 and data_o holds its last value.
- Credit counter: cnt_next = cnt - fire + credit_i.
  - fire and credit_i in the same cycle leave cnt unchanged.
  - A credit arriving while cnt == 0 raises ready_o in the following cycle, not the same cycle.
- Overflow: credit_i while cnt == CREDITS and no fire.
  - cnt saturates at CREDITS.
  - err_o <= 1 and stays set until reset.
- Underflow is impossible by construction, because fire requires cnt != 0.
- credits_o = cnt.
- FSM states:
  - RUN: normal operation. If flush_req_i is 1, go to DRAIN; ready_o is already 0 from the next cycle.
  - DRAIN: ready_o = 0. When cnt_next == CREDITS and valid_o == 0, go to DONE.
  - DONE: flush_done_o = 1 (registered, asserted during DONE). When flush_req_i == 0, go to RUN and flush_done_o <= 0.
- flush_req_i is sampled in RUN. A word firing in the same cycle that flush_req_i rises is still sent and must be credited back before DONE.
- A flush requested while already drained (cnt == CREDITS) reaches DONE in 2 cycles: RUN to DRAIN, then DRAIN to DONE.
- credit_i is honoured in every state.
- Asynchronous reset mid-transfer drops any in-flight valid_o and restores the full credit count. The remote buffer must be reset in the same domain.

Decomposition:
- Shared package ext_ipa_pkg holds:
  - typedef enum logic [1:0] {TX_RUN, TX_DRAIN, TX_DONE} ext_tx_state_e.
  - localparam EXT_DEFAULT_DEPTH = 2, used as the default for both CREDITS and the receive-buffer depth so the two cannot diverge.
- One natural sub-module, ext_credit_cnt_ipa: an up/down saturating counter with ports inc, dec, count, full, empty and overflow. The FSM and output register stay in the top.

Test Plan:
- Reset, then valid_i=1 with data 0xA0, 0xA1, 0xA2 and no credit_i (CREDITS=2):
  - valid_o pulses at cycles 1 and 2 carrying 0xA0 and 0xA1.
  - ready_o=0 from cycle 2; 0xA2 is held upstream.
  - credits_o goes 2, 1, 0.
- From cnt=0, pulse credit_i once:
  - ready_o=1 the next cycle; 0xA2 is sent; cnt ends at 0.
- cnt=1, with valid_i=1 and credit_i=1 in the same cycle:
  - word is sent; credits_o stays 1.
  - sustained traffic with a credit every cycle gives 100% throughput.
- cnt=2, credit_i pulse with no fire:
  - err_o=1 next cycle; credits_o stays 2; err_o persists until rst_ni is low.
- Send 2 words, then raise flush_req_i:
  - state goes to DRAIN and ready_o=0.
  - after 2 credit_i pulses, flush_done_o=1 one cycle later.
  - drop flush_req_i: flush_done_o=0 and ready_o=1 next cycle.
- Assert rst_ni low while valid_o=1 and cnt=0:
  - valid_o=0, credits_o=2, state RUN and err_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ext_ipa_pkg.sv
// Shared types and defaults for the ext-unit IPA credit link.
package ext_ipa_pkg;

   // Transmit-side link state.
   typedef enum logic [1:0] {
      TX_RUN,
      TX_DRAIN,
      TX_DONE
   } ext_tx_state_e;

   // Remote receive-buffer depth; also the default credit count so the two stay equal.
   localparam int unsigned EXT_DEFAULT_DEPTH = 2;

endpackage : ext_ipa_pkg

// File: rtl/ext_credit_cnt_ipa.sv
// Up/down saturating credit counter; resets to MAX (all credits home).
module ext_credit_cnt_ipa
   import ext_ipa_pkg::*;
#(
   parameter int unsigned MAX = EXT_DEFAULT_DEPTH,
   parameter int unsigned W   = $clog2(MAX + 1)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         overflow_o
);

   localparam logic [W-1:0] MaxVal = W'(MAX);

   logic [W-1:0] count_q, count_d;

   assign full_o     = (count_q == MaxVal);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   // Returning a credit while already full with nothing consumed is a protocol error.
   assign overflow_o = inc_i && !dec_i && full_o;

   // Next count: inc and dec together cancel; saturate at both ends.
   always_comb begin
      count_d = count_q;
      case ({inc_i, dec_i})
         2'b10:   if (!full_o)  count_d = count_q + W'(1);
         2'b01:   if (!empty_o) count_d = count_q - W'(1);
         default: count_d = count_q;
      endcase
   end

   // Count register, full on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= MaxVal;
      else         count_q <= count_d;
   end

endmodule : ext_credit_cnt_ipa

// File: rtl/ext_credit_tx_ipa.sv
// Credit-based link transmitter with drain/flush control for IPA reconfiguration.
module ext_credit_tx_ipa
   import ext_ipa_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CREDITS    = EXT_DEFAULT_DEPTH,
   parameter int unsigned CNT_WIDTH  = $clog2(CREDITS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  credit_i,
   output logic [CNT_WIDTH-1:0]  credits_o,
   input  logic                  flush_req_i,
   output logic                  flush_done_o,
   output logic                  err_o
);

   ext_tx_state_e         state_q;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  flush_done_q;
   logic                  err_q;

   logic                  fire;
   logic                  cnt_full;
   logic                  cnt_empty;
   logic                  cnt_overflow;
   logic                  drained;

   // Ready depends only on registered state, never on credit_i or valid_i.
   assign ready_o = (state_q == TX_RUN) && !cnt_empty;
   assign fire    = valid_i && ready_o;

   ext_credit_cnt_ipa #(
      .MAX (CREDITS),
      .W   (CNT_WIDTH)
   ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (credit_i),
      .dec_i      (fire),
      .count_o    (credits_o),
      .full_o     (cnt_full),
      .empty_o    (cnt_empty),
      .overflow_o (cnt_overflow)
   );

   // In DRAIN nothing fires, so the next count is full when already full or the last credit lands now.
   assign drained = !valid_q &&
                    (cnt_full || (credit_i && (credits_o == CNT_WIDTH'(CREDITS - 1))));

   // Link output register, sticky error and flush FSM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= TX_RUN;
         valid_q      <= 1'b0;
         data_q       <= '0;
         flush_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         valid_q <= fire;
         if (fire)         data_q <= data_i;
         if (cnt_overflow) err_q  <= 1'b1;
         case (state_q)
            TX_RUN: begin
               if (flush_req_i) state_q <= TX_DRAIN;
            end
            TX_DRAIN: begin
               if (drained) begin
                  state_q      <= TX_DONE;
                  flush_done_q <= 1'b1;
               end
            end
            TX_DONE: begin
               if (!flush_req_i) begin
                  state_q      <= TX_RUN;
                  flush_done_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= TX_RUN;
               flush_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign flush_done_o = flush_done_q;
   assign err_o        = err_q;

endmodule : ext_credit_tx_ipa

// File: tb/tb_ext_credit_tx_ipa.sv
// Directed self-checking bench for ext_credit_tx_ipa (CREDITS = 2).
module tb_ext_credit_tx_ipa;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 2;

   logic          clk_i;
   logic          rst_ni;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          ready_o;
   logic          valid_o;
   logic [DW-1:0] data_o;
   logic          credit_i;
   logic [CW-1:0] credits_o;
   logic          flush_req_i;
   logic          flush_done_o;
   logic          err_o;

   int n_run;
   int n_fail;

   ext_credit_tx_ipa #(
      .DATA_WIDTH (DW),
      .CREDITS    (2),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .valid_i      (valid_i),
      .data_i       (data_i),
      .ready_o      (ready_o),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .credit_i     (credit_i),
      .credits_o    (credits_o),
      .flush_req_i  (flush_req_i),
      .flush_done_o (flush_done_o),
      .err_o        (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni      = 1'b0;
      valid_i     = 1'b0;
      data_i      = '0;
      credit_i    = 1'b0;
      flush_req_i = 1'b0;
      tick();
      tick();
      n_run++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", valid_o); end
      n_run++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", data_o); end
      n_run++; if (credits_o !== 2'd2) begin n_fail++; $display("FAIL rst_credits: got %0d want 2", credits_o); end
      n_run++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", ready_o); end
      n_run++; if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", flush_done_o); end
      n_run++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err_o); end
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_send_until_empty();
      valid_i = 1'b1;
      data_i  = 32'hA0;
      tick();
      n_run++; if (valid_o !== 1'b1 || data_o !== 32'hA0) begin n_fail++; $display("FAIL a0_out: got v=%0b d=%0h want v=1 d=a0", valid_o, data_o); end
      n_run++; if (credits_o !== 2'd1) begin n_fail++; $display("FAIL a0_credits: got %0d want 1", credits_o); end
      data_i = 32'hA1;
      tick();
      n_run++; if (valid_o !== 1'b1 || data_o !== 32'hA1) begin n_fail++; $display("FAIL a1_out: got v=%0b d=%0h want v=1 d=a1", valid_o, data_o); end
      n_run++; if (credits_o !== 2'd0) begin n_fail++; $display("FAIL a1_credits: got %0d want 0", credits_o); end
      n_run++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL a1_ready: got %0b want 0", ready_o); end
      data_i = 32'hA2;
      tick();
      n_run++; if (valid_o !== 1'b0 || data_o !== 32'hA1) begin n_fail++; $display("FAIL a2_held: got v=%0b d=%0h want v=0 d=a1", valid_o, data_o); end
      n_run++; if (credits_o !== 2'd0) begin n_fail++; $display("FAIL a2_credits: got %0d want 0", credits_o); end
   endtask

   task automatic test_credit_return();
      credit_i = 1'b1;
      #1;
      n_run++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL cr_same_cycle_ready: got %0b want 0", ready_o); end
      tick();
      credit_i = 1'b0;
      n_run++; if (ready_o !== 1'b1 || credits_o !== 2'd1) begin n_fail++; $display("FAIL cr_next_ready: got r=%0b c=%0d want r=1 c=1", ready_o, credits_o); end
      n_run++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL cr_no_send: got %0b want 0", valid_o); end
      tick();
      n_run++; if (valid_o !== 1'b1 || data_o !== 32'hA2) begin n_fail++; $display("FAIL cr_a2_out: got v=%0b d=%0h want v=1 d=a2", valid_o, data_o); end
      n_run++; if (credits_o !== 2'd0) begin n_fail++; $display("FAIL cr_end_credits: got %0d want 0", credits_o); end
      valid_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      credit_i = 1'b1;
      tick();
      n_run++; if (credits_o !== 2'd1) begin n_fail++; $display("FAIL b2b_setup: got %0d want 1", credits_o); end
      valid_i = 1'b1;
      data_i  = 32'hB0;
      tick();
      n_run++; if (valid_o !== 1'b1 || data_o !== 32'hB0 || credits_o !== 2'd1) begin n_fail++; $display("FAIL b2b_simul: got v=%0b d=%0h c=%0d want v=1 d=b0 c=1", valid_o, data_o, credits_o); end
      for (int i = 1; i <= 4; i++) begin
         data_i = 32'hB0 + 32'(i);
         tick();
         n_run++; if (valid_o !== 1'b1 || data_o !== 32'hB0 + 32'(i) || credits_o !== 2'd1) begin n_fail++; $display("FAIL b2b_stream%0d: got v=%0b d=%0h c=%0d want v=1 d=%0h c=1", i, valid_o, data_o, credits_o, 32'hB0 + 32'(i)); end
      end
      valid_i = 1'b0;
      tick();
      n_run++; if (credits_o !== 2'd2 || valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_refill: got c=%0d v=%0b want c=2 v=0", credits_o, valid_o); end
      n_run++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_err: got %0b want 0", err_o); end
      credit_i = 1'b0;
      tick();
   endtask

   task automatic test_overflow();
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      n_run++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %0b want 1", err_o); end
      n_run++; if (credits_o !== 2'd2) begin n_fail++; $display("FAIL ovf_sat: got %0d want 2", credits_o); end
      tick();
      tick();
      n_run++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", err_o); end
   endtask

   task automatic test_flush();
      valid_i = 1'b1;
      data_i  = 32'hC0;
      tick();
      data_i = 32'hC1;
      tick();
      valid_i     = 1'b0;
      flush_req_i = 1'b1;
      tick();
      n_run++; if (ready_o !== 1'b0 || flush_done_o !== 1'b0) begin n_fail++; $display("FAIL fl_drain_entry: got r=%0b d=%0b want r=0 d=0", ready_o, flush_done_o); end
      credit_i = 1'b1;
      tick();
      n_run++; if (ready_o !== 1'b0 || credits_o !== 2'd1 || flush_done_o !== 1'b0) begin n_fail++; $display("FAIL fl_drain_hold: got r=%0b c=%0d d=%0b want r=0 c=1 d=0", ready_o, credits_o, flush_done_o); end
      tick();
      credit_i = 1'b0;
      n_run++; if (flush_done_o !== 1'b1 || credits_o !== 2'd2 || ready_o !== 1'b0) begin n_fail++; $display("FAIL fl_done: got d=%0b c=%0d r=%0b want d=1 c=2 r=0", flush_done_o, credits_o, ready_o); end
      tick();
      n_run++; if (flush_done_o !== 1'b1) begin n_fail++; $display("FAIL fl_done_hold: got %0b want 1", flush_done_o); end
      flush_req_i = 1'b0;
      tick();
      n_run++; if (flush_done_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL fl_release: got d=%0b r=%0b want d=0 r=1", flush_done_o, ready_o); end
   endtask

   task automatic test_flush_idle();
      flush_req_i = 1'b1;
      tick();
      n_run++; if (flush_done_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL fi_drain: got d=%0b r=%0b want d=0 r=0", flush_done_o, ready_o); end
      tick();
      n_run++; if (flush_done_o !== 1'b1) begin n_fail++; $display("FAIL fi_done: got %0b want 1", flush_done_o); end
      flush_req_i = 1'b0;
      tick();
      n_run++; if (flush_done_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL fi_release: got d=%0b r=%0b want d=0 r=1", flush_done_o, ready_o); end
   endtask

   task automatic test_flush_with_fire();
      valid_i     = 1'b1;
      data_i      = 32'hD0;
      flush_req_i = 1'b1;
      tick();
      valid_i = 1'b0;
      n_run++; if (valid_o !== 1'b1 || data_o !== 32'hD0 || credits_o !== 2'd1) begin n_fail++; $display("FAIL ff_sent: got v=%0b d=%0h c=%0d want v=1 d=d0 c=1", valid_o, data_o, credits_o); end
      n_run++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL ff_ready: got %0b want 0", ready_o); end
      tick();
      tick();
      n_run++; if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL ff_wait: got %0b want 0", flush_done_o); end
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      n_run++; if (flush_done_o !== 1'b1 || credits_o !== 2'd2) begin n_fail++; $display("FAIL ff_done: got d=%0b c=%0d want d=1 c=2", flush_done_o, credits_o); end
      flush_req_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_transfer();
      valid_i = 1'b1;
      data_i  = 32'hE0;
      tick();
      data_i = 32'hE1;
      tick();
      valid_i = 1'b0;
      n_run++; if (valid_o !== 1'b1 || credits_o !== 2'd0) begin n_fail++; $display("FAIL rm_setup: got v=%0b c=%0d want v=1 c=0", valid_o, credits_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      n_run++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %0b want 0", valid_o); end
      n_run++; if (credits_o !== 2'd2) begin n_fail++; $display("FAIL rm_credits: got %0d want 2", credits_o); end
      n_run++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rm_err: got %0b want 0", err_o); end
      n_run++; if (ready_o !== 1'b1 || flush_done_o !== 1'b0) begin n_fail++; $display("FAIL rm_state: got r=%0b d=%0b want r=1 d=0", ready_o, flush_done_o); end
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      test_reset();
      test_send_until_empty();
      test_credit_return();
      test_back_to_back();
      test_overflow();
      test_flush();
      test_flush_idle();
      test_flush_with_fire();
      test_reset_mid_transfer();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule : tb_ext_credit_tx_ipa
